// File: rtl/latch_write_sequencer_if.sv
// Request/acknowledge and latch-array bus for latch_write_sequencer.
// AW may be widened beyond $clog2(NCELL) so out-of-range word addresses can be expressed.
interface latch_write_sequencer_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int NCELL = 8,
  parameter int AW    = (NCELL > 1) ? $clog2(NCELL) : 1
);
  logic [NREQ-1:0]       req;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       ack;
  logic                  err;
  logic                  busy;
  logic [2:0]            gnt_id;
  logic [WIDTH-1:0]      lat_d;
  logic [NCELL-1:0]      lat_gate;

  modport master (
    output req, req_addr, req_data,
    input  ack, err, busy, gnt_id, lat_d, lat_gate
  );

  modport slave (
    input  req, req_addr, req_data,
    output ack, err, busy, gnt_id, lat_d, lat_gate
  );
endinterface

// File: rtl/latch_write_sequencer.sv
// Arbitrated write sequencer for a gated-D latch word bank: setup, gate pulse, hold, ack.
// Define LWS_RR_ARB_EN for round-robin arbitration; otherwise lowest index wins.
module latch_write_sequencer #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int NCELL    = 8,
  parameter int AW       = (NCELL > 1) ? $clog2(NCELL) : 1,
  parameter int GATE_CYC = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  latch_write_sequencer_if.slave bus
);

  localparam int CW = (GATE_CYC > 1) ? $clog2(GATE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(GATE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    GATE  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;

  logic [AW-1:0]    r_addr;
  logic [WIDTH-1:0] r_data;
  logic [2:0]       r_gnt_id;
  logic [NREQ-1:0]  r_ack;
  logic             r_err;
  logic             r_busy;
  logic [NCELL-1:0] r_lat_gate;

  logic             w_grant;
  logic [2:0]       w_sel_id;
  logic [AW-1:0]    w_sel_addr;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_addr_ok;

  // First requester at or above 'start', searching upward with wrap-around.
  function automatic logic [2:0] f_pick(input logic [NREQ-1:0] req, input logic [2:0] start);
    logic [2:0] sel;
    logic       found;
    int         j;
    sel   = 3'd0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(start) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j]) begin
        found = 1'b1;
        sel   = 3'(j);
      end
    end
    return sel;
  endfunction

  function automatic logic [NCELL-1:0] f_gate_decode(input logic [AW-1:0] addr);
    logic [NCELL-1:0] dec;
    for (int c = 0; c < NCELL; c++) dec[c] = (int'(addr) == c);
    return dec;
  endfunction

  function automatic logic [NREQ-1:0] f_onehot(input logic [2:0] id);
    logic [NREQ-1:0] oh;
    for (int i = 0; i < NREQ; i++) oh[i] = (int'(id) == i);
    return oh;
  endfunction

  assign w_grant    = (r_state == IDLE) && (|bus.req);
  assign w_sel_addr = bus.req_addr[int'(w_sel_id)*AW +: AW];
  assign w_sel_data = bus.req_data[int'(w_sel_id)*WIDTH +: WIDTH];
  assign w_addr_ok  = (int'(r_addr) < NCELL);

`ifdef LWS_RR_ARB_EN
  logic [2:0] r_ptr;

  // Pointer sits one past the last grant so every requester gets a turn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 3'd0;
    end else if (w_grant) begin
      r_ptr <= (int'(w_sel_id) == NREQ - 1) ? 3'd0 : w_sel_id + 3'd1;
    end
  end

  assign w_sel_id = f_pick(bus.req, r_ptr);
`else
  assign w_sel_id = f_pick(bus.req, 3'd0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_grant) w_state_nxt = SETUP;
      end
      SETUP: begin
        w_state_nxt = GATE;
        w_cnt_nxt   = CNT_LOAD;
      end
      GATE: begin
        if (r_cnt == '0) w_state_nxt = HOLD;
        else             w_cnt_nxt   = r_cnt - CW'(1);
      end
      HOLD: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Requests are captured only at grant; later input changes cannot disturb the write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr   <= '0;
      r_data   <= '0;
      r_gnt_id <= 3'd0;
    end else if (w_grant) begin
      r_addr   <= w_sel_addr;
      r_data   <= w_sel_data;
      r_gnt_id <= w_sel_id;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= 1'b0;
      r_lat_gate <= '0;
      r_ack      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_busy     <= (w_state_nxt != IDLE);
      r_lat_gate <= ((w_state_nxt == GATE) && w_addr_ok) ? f_gate_decode(r_addr) : '0;
      r_ack      <= (w_state_nxt == HOLD) ? f_onehot(r_gnt_id) : '0;
      r_err      <= (w_state_nxt == HOLD) && !w_addr_ok;
    end
  end

  assign bus.ack      = r_ack;
  assign bus.err      = r_err;
  assign bus.busy     = r_busy;
  assign bus.gnt_id   = r_gnt_id;
  assign bus.lat_d    = r_data;
  assign bus.lat_gate = r_lat_gate;

  a_gate_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(r_lat_gate));
  a_ack_onehot0:  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(r_ack));
  a_err_with_ack: assert property (@(posedge clk) disable iff (!rst_n) r_err |-> (|r_ack));

endmodule

// File: tb/tb_latch_write_sequencer.sv
// Bench for latch_write_sequencer: timeline model checked every cycle plus directed pins.
module tb_latch_write_sequencer;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int NCELL = 8;
  localparam int AW    = 4;
  localparam int GC    = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int n_pass  = 0;
  int n_total = 0;

  int               m_k;
  int               m_id;
  int               m_addr;
  int               m_ptr;
  logic [WIDTH-1:0] m_data;

  logic [NREQ-1:0]  e_ack;
  logic             e_err;
  logic             e_busy;
  logic [2:0]       e_gnt;
  logic [WIDTH-1:0] e_latd;
  logic [NCELL-1:0] e_gate;

  latch_write_sequencer_if #(.NREQ(NREQ), .WIDTH(WIDTH), .NCELL(NCELL), .AW(AW)) bus ();

  latch_write_sequencer #(
    .NREQ(NREQ), .WIDTH(WIDTH), .NCELL(NCELL), .AW(AW), .GATE_CYC(GC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model: an operation is a fixed timeline of GC+2 cycles after the sampling IDLE cycle.
  task automatic model_outputs();
    e_busy = (m_k != 0);
    e_gate = '0;
    if (m_k >= 2 && m_k <= GC + 1 && m_addr < NCELL) e_gate[m_addr] = 1'b1;
    e_ack = '0;
    e_err = 1'b0;
    if (m_k == GC + 2) begin
      e_ack[m_id] = 1'b1;
      e_err       = (m_addr >= NCELL);
    end
    e_gnt  = 3'(m_id);
    e_latd = m_data;
  endtask

  task automatic model_reset();
    m_k = 0; m_id = 0; m_addr = 0; m_ptr = 0; m_data = '0;
    model_outputs();
  endtask

  task automatic model_step();
    int id;
    id = -1;
    if (m_k == 0) begin
      if (bus.req != '0) begin
        for (int k = 0; k < NREQ; k++)
          if (id < 0 && bus.req[(m_ptr + k) % NREQ]) id = (m_ptr + k) % NREQ;
        m_id   = id;
        m_addr = int'(bus.req_addr[id*AW +: AW]);
        m_data = bus.req_data[id*WIDTH +: WIDTH];
`ifdef LWS_RR_ARB_EN
        m_ptr  = (id + 1) % NREQ;
`endif
        m_k    = 1;
      end
    end else if (m_k == GC + 2) begin
      m_k = 0;
    end else begin
      m_k++;
    end
    model_outputs();
  endtask

  task automatic drive(input int id, input int addr, input int data);
    bus.req[id]                  = 1'b1;
    bus.req_addr[id*AW +: AW]    = AW'(addr);
    bus.req_data[id*WIDTH +: WIDTH] = WIDTH'(data);
  endtask

  task automatic wait_ack(input int budget, output int cyc);
    cyc = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (bus.ack != '0) begin
        cyc = c;
        break;
      end
    end
  endtask

  initial begin
    int cyc;
    int n_ack;
    int exp_id;
    bus.req      = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    model_reset();
    fork
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else        model_step();
      end
      forever begin
        @(negedge clk);
        check("cmp_ack",  32'(bus.ack),      32'(e_ack));
        check("cmp_err",  32'(bus.err),      32'(e_err));
        check("cmp_busy", 32'(bus.busy),     32'(e_busy));
        check("cmp_gnt",  32'(bus.gnt_id),   32'(e_gnt));
        check("cmp_latd", 32'(bus.lat_d),    32'(e_latd));
        check("cmp_gate", 32'(bus.lat_gate), 32'(e_gate));
      end
      begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_gate", 32'(bus.lat_gate), 32'd0);
        check("rst_latd", 32'(bus.lat_d), 32'd0);
        check("rst_ack",  32'(bus.ack), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single write: requester 0, word 3, data A5.
        @(negedge clk);
        drive(0, 3, 8'hA5);
        @(negedge clk);
        check("t1_setup_latd", 32'(bus.lat_d), 32'hA5);
        check("t1_setup_gate", 32'(bus.lat_gate), 32'h00);
        check("t1_setup_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check("t1_gate_c1", 32'(bus.lat_gate), 32'h08);
        @(negedge clk);
        check("t1_gate_c2", 32'(bus.lat_gate), 32'h08);
        @(negedge clk);
        check("t1_hold_ack",  32'(bus.ack), 32'b0001);
        check("t1_hold_err",  32'(bus.err), 32'd0);
        check("t1_hold_gate", 32'(bus.lat_gate), 32'h00);
        bus.req = '0;
        @(negedge clk);
        check("t1_idle_busy", 32'(bus.busy), 32'd0);
        check("t1_idle_latd", 32'(bus.lat_d), 32'hA5);

        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;

        // All four requesters held continuously.
        for (int i = 0; i < NREQ; i++) drive(i, i + 1, 8'h10 + i);
        for (int n = 0; n < 5; n++) begin
          wait_ack(8, cyc);
          check("t2_ack_spacing", 32'(cyc), (n == 0) ? 32'd4 : 32'd5);
`ifdef LWS_RR_ARB_EN
          exp_id = n % NREQ;
`else
          exp_id = 0;
`endif
          check("t2_gnt_order", 32'(bus.gnt_id), 32'(exp_id));
          check("t2_ack_bit",   32'(bus.ack), 32'(1 << exp_id));
        end
        bus.req = '0;

        // Out-of-range address from requester 2.
        @(negedge clk);
        drive(2, 9, 8'h3C);
        for (int c = 1; c <= 4; c++) begin
          @(negedge clk);
          check("t3_gate_low", 32'(bus.lat_gate), 32'h00);
        end
        check("t3_ack", 32'(bus.ack), 32'b0100);
        check("t3_err", 32'(bus.err), 32'd1);
        bus.req = '0;

        // Inputs change mid-operation for requester 1; requester 3 arrives.
        @(negedge clk);
        drive(1, 5, 8'h11);
        @(negedge clk);
        check("t5_setup_latd", 32'(bus.lat_d), 32'h11);
        bus.req_data[1*WIDTH +: WIDTH] = 8'h22;
        drive(3, 6, 8'h33);
        @(negedge clk);
        @(negedge clk);
        check("t5_gate_latd", 32'(bus.lat_d), 32'h11);
        check("t5_gate_word", 32'(bus.lat_gate), 32'h20);
        @(negedge clk);
        check("t5_hold_ack",  32'(bus.ack), 32'b0010);
        check("t5_hold_latd", 32'(bus.lat_d), 32'h11);
        bus.req[1] = 1'b0;
        @(negedge clk);
        check("t5_idle_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check("t5_next_gnt",  32'(bus.gnt_id), 32'd3);
        check("t5_next_latd", 32'(bus.lat_d), 32'h33);
        wait_ack(6, cyc);
        check("t5_req3_ack_cyc", 32'(cyc), 32'd3);
        check("t5_req3_ack", 32'(bus.ack), 32'b1000);
        bus.req = '0;

        // Asynchronous reset during the gate pulse; request held across it.
        @(negedge clk);
        drive(0, 2, 8'h5A);
        @(negedge clk);
        @(negedge clk);
        check("t4_pre_gate", 32'(bus.lat_gate), 32'h04);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t4_async_gate", 32'(bus.lat_gate), 32'h00);
        check("t4_async_busy", 32'(bus.busy), 32'd0);
        check("t4_async_ack",  32'(bus.ack), 32'd0);
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        wait_ack(8, cyc);
        check("t4_after_ack_cyc", 32'(cyc), 32'd4);
        check("t4_after_ack", 32'(bus.ack), 32'b0001);
        check("t4_after_latd", 32'(bus.lat_d), 32'h5A);
        bus.req = '0;
        n_ack = 0;
        for (int c = 0; c < 6; c++) begin
          @(negedge clk);
          if (bus.ack != '0) n_ack++;
        end
        check("t4_served_once", 32'(n_ack), 32'd0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
      end
    join
  end

endmodule

// File: doc/latch_write_sequencer.md
# latch_write_sequencer

Sequences write accesses into a bank of level-sensitive gated D latch words (NAND-latch storage cells, one gate input per word). Several requesters share the bank; the block arbitrates between them, presents the write data, and generates a non-overlapping gate pulse with data setup and hold margins around it. It sits between the requesting logic and the latch array, and is the only driver of the array's data and gate lines.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `WIDTH`, 8: latch word width in bits.
- `NCELL`, 8: number of latch words. `AW = $clog2(NCELL)`, minimum 1.
- `GATE_CYC`, 2: gate-high duration in clock cycles (≥1).

- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  per-requester write request, level; held until its `ack` is seen.
- `req_addr`  in  NREQ*AW  packed word addresses; requester i uses bits [i*AW +: AW].
- `req_data`  in  NREQ*WIDTH  packed write data; requester i uses bits [i*WIDTH +: WIDTH].
- `ack`  out  NREQ  one-hot, one-cycle completion pulse to the served requester.
- `err`  out  1  one-cycle pulse, coincident with `ack`, when the served address ≥ NCELL.
- `busy`  out  1  high in every state except IDLE.
- `gnt_id`  out  3  index of the requester currently being served; holds its last value in IDLE.
- `lat_d`  out  WIDTH  data bus to all latch D inputs.
- `lat_gate`  out  NCELL  per-word gate (latch enable), at most one bit high.

## Operation
- FSM states: IDLE, SETUP, GATE, HOLD.
- IDLE: if any `req` bit is high, select one requester per the arbitration rule and capture its address and data into internal registers. Set `gnt_id`, then go to SETUP. If no request is pending, stay in IDLE.
- SETUP (1 cycle): `lat_d` = captured data; all gates low.
- GATE (GATE_CYC cycles): `lat_gate[addr]` high and `lat_d` stable. A down-counter loaded with GATE_CYC-1 sets the duration. If addr ≥ NCELL, all gates stay low.
- HOLD (1 cycle): gates low and `lat_d` still stable. `ack[gnt_id]` is high, and `err` is high if addr ≥ NCELL. Then return to IDLE.
- `req`, `req_addr` and `req_data` are sampled only in IDLE. Changes during an operation are ignored, and a request dropped mid-operation still completes.
- Arbitration: round-robin or fixed priority, selected as described under Configuration. The round-robin pointer is the index after the last-granted requester, wrapping at NREQ. The search runs upward from the pointer with wrap-around. The pointer updates only on grant.
- `lat_d` keeps its last value in IDLE and does not return to 0.
- All outputs are registered. `lat_gate` is decoded from registered state only, so it cannot glitch.

## Timing
- Reset values: state IDLE, `ack`=0, `err`=0, `busy`=0, `gnt_id`=0, `lat_d`=0, `lat_gate`=0, RR pointer 0, counter 0.
- Reset is asynchronous. Asserting `rst_n` mid-operation drops `lat_gate` immediately; the latch keeps whatever it captured. No `ack` is issued for an aborted operation.
- Service time is GATE_CYC+3 cycles, from the IDLE cycle that samples `req` to the next IDLE. `ack` falls in the last of these cycles (HOLD).
- Data setup to gate rise: 1 cycle. Data hold after gate fall: 1 cycle.
- Gate non-overlap: with back-to-back requests there are ≥3 gate-low cycles between the gate pulses of two operations (HOLD, IDLE, SETUP).
- Requester protocol: drop `req` on the edge where `ack` is seen. A `req` still high in the following IDLE cycle is treated as a new request.
- If several requests are pending, exactly one is granted per IDLE cycle. Throughput is one write per GATE_CYC+3 cycles.

## Configuration
- `LWS_RR_ARB_EN` defined: round-robin arbitration as above.
- `LWS_RR_ARB_EN` undefined: fixed priority, lowest index wins. The pointer register is not built, and `gnt_id` and everything else behave identically.

## Test plan
- Reset, then `req`=4'b0001, addr 3, data 8'hA5. Expect `lat_d`=A5 in SETUP, `lat_gate`=8'h08 for exactly 2 cycles, `ack`=4'b0001 in cycle 5 after the request is sampled, `err`=0.
- All four requests held high continuously (RR build). Expect grant order 0,1,2,3,0 with `ack` pulses 5 cycles apart and never two `lat_gate` bits high together. Fixed-priority build: requester 0 is granted every time.
- Requester 2 issues addr 9 with NCELL=8 and data 8'h3C. Expect `lat_gate` to stay 0 throughout, `ack`=4'b0100 and `err`=1 in the same cycle.
- Pulse `rst_n` low during the GATE state. Expect `lat_gate`=0 asynchronously, no `ack`, `busy`=0. A request held across reset is served once reset is released.
- During an operation for requester 1, change `req_data[1]` and raise `req[3]`. Expect `lat_d` to keep the captured data through HOLD, and requester 3 to be granted in the following IDLE cycle.
